// File: rtl/mem_arbiter.sv
// Shares the single-port core memory between instruction fetch and load/store.
// Latency: grant in the request cycle (combinational), response registered one cycle later.
// Backpressure: a requester holds req until gnt; data wins contention, at most MAX_STREAK times in a row while fetch waits.
module mem_arbiter #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [3:0] streak;
  logic       d_win;
  logic       d_aligned;

  assign d_aligned      = (d_addr[1:0] == 2'b00);
  assign mem_write_data = d_wdata;

  // Arbitration and memory drive: data wins unless fetch has already waited out
  // MAX_STREAK consecutive data grants. Grants are held off while in reset so
  // no write can reach the memory then. Misaligned stores are granted but never written.
  always_comb begin
    d_win            = d_req && (!if_req || (streak < STREAK_MAX));
    d_gnt            = rst_n && d_win;
    if_gnt           = rst_n && if_req && !d_win;
    mem_address      = d_gnt ? d_addr : if_addr;
    mem_write_enable = d_gnt && d_we && d_aligned;
  end

  // Streak of data grants taken while fetch was waiting; any idle-fetch cycle
  // or fetch grant restarts it, and it saturates at MAX_STREAK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= 4'd0;
    end else if (!if_req || if_gnt) begin
      streak <= 4'd0;
    end else if (d_gnt && (streak < STREAK_MAX)) begin
      streak <= streak + 4'd1;
    end
  end

  // Response capture: one-cycle rvalid pulse after each grant. Load data is only
  // captured for aligned loads, so stores and misaligned accesses keep d_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'h0;
      d_rvalid  <= 1'b0;
      d_rdata   <= 32'h0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_gnt;
      d_err     <= d_gnt && !d_aligned;
      if (if_gnt) begin
        if_rdata <= mem_read_data;
      end
      if (d_gnt && !d_we && d_aligned) begin
        d_rdata <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbiter and the memory contents.
module tb_mem_arbiter;

  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      1:       return 32'h12345678;
      2:       return 32'hABCDEF01;
      default: return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endcase
  endfunction

  // Environment memory: 64 words, combinational read, write on the clock edge.
  logic        preload;
  logic [31:0] mem [0:63];
  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_write_enable) begin
      mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  // Reference model: expected memory image and expected response registers.
  logic [31:0] ref_mem [0:63];
  int          run;
  logic        exp_if_rvalid, exp_d_rvalid, exp_d_err;
  logic [31:0] exp_if_rdata, exp_d_rdata;

  function automatic logic model_d_wins();
    return d_req && (!if_req || run < MAX_STREAK);
  endfunction

  // Model update late in each cycle, after inputs are stable, before the edge.
  always @(negedge clk) begin
    logic md, mi;
    #3;
    if (preload) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    end
    if (!rst_n) begin
      run = 0;
      exp_if_rvalid = 1'b0; exp_d_rvalid = 1'b0; exp_d_err = 1'b0;
      exp_if_rdata = 32'h0; exp_d_rdata = 32'h0;
    end else begin
      md = model_d_wins();
      mi = if_req && !md;
      exp_if_rvalid = mi;
      if (mi) exp_if_rdata = ref_mem[if_addr[7:2]];
      exp_d_rvalid = md;
      exp_d_err    = md && (d_addr[1:0] != 2'b00);
      if (md && d_addr[1:0] == 2'b00) begin
        if (d_we) ref_mem[d_addr[7:2]] = d_wdata;
        else      exp_d_rdata = ref_mem[d_addr[7:2]];
      end
      if (!if_req || mi) run = 0;
      else if (md && run < MAX_STREAK) run = run + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; preload = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin errors++; $display("FAIL reset_prestream_dgnt got %b exp 1", d_gnt); end
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, mem_write_enable, if_rvalid, d_rvalid, d_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {if_gnt, d_gnt, mem_write_enable, if_rvalid, d_rvalid, d_err});
    end
    checks++;
    if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", if_rdata, d_rdata);
    end
    step();
    rst_n = 1'b1; d_req = 1'b0; if_addr = 32'h4;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_first_grant got if=%b d=%b exp if=1 d=0", if_gnt, d_gnt);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h12345678) begin
      errors++; $display("FAIL reset_first_resp got %b %h exp 1 12345678", if_rvalid, if_rdata);
    end
    step();
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 32'h4;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || mem_address !== 32'h4) begin
      errors++; $display("FAIL fetch_gnt got %b addr %h exp 1 00000004", if_gnt, mem_address);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h12345678 || d_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_resp got %b %h d_rvalid %b exp 1 12345678 0", if_rvalid, if_rdata, d_rvalid);
    end
    step();
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_address !== 32'h8) begin
      errors++; $display("FAIL contend_first got d=%b if=%b addr %h exp d=1 if=0 00000008", d_gnt, if_gnt, mem_address);
    end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hABCDEF01 || d_err !== 1'b0) begin
      errors++; $display("FAIL contend_dresp got %b %h err %b exp 1 abcdef01 0", d_rvalid, d_rdata, d_err);
    end
    checks++;
    if (if_gnt !== 1'b1 || mem_address !== 32'h10) begin
      errors++; $display("FAIL contend_ifgnt got %b addr %h exp 1 00000010", if_gnt, mem_address);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== init_word(4)) begin
      errors++; $display("FAIL contend_ifresp got %b %h exp 1 %h", if_rvalid, if_rdata, init_word(4));
    end
    step();
  endtask

  task automatic test_starvation();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic fexp;
      fexp = ((i % 5) == 4);
      d_addr = 32'(i % 8) << 2;
      @(negedge clk);
      checks++;
      if (if_gnt !== fexp || d_gnt !== !fexp) begin
        errors++; $display("FAIL starve_cycle%0d got if=%b d=%b exp if=%b d=%b", i, if_gnt, d_gnt, fexp, !fexp);
      end
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_write_enable !== 1'b1 || mem_write_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL store_drive got gnt %b we %b wd %h exp 1 1 cafef00d", d_gnt, mem_write_enable, mem_write_data);
    end
    step();
    d_we = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_err !== 1'b0 || mem_write_enable !== 1'b0) begin
      errors++; $display("FAIL store_resp got rv %b err %b we %b exp 1 0 0", d_rvalid, d_err, mem_write_enable);
    end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL raw_load got %b %h exp 1 cafef00d", d_rvalid, d_rdata);
    end
    step();
  endtask

  task automatic test_misaligned();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6; d_wdata = 32'h11111111;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_write_enable !== 1'b0) begin
      errors++; $display("FAIL misal_drive got gnt %b we %b exp 1 0", d_gnt, mem_write_enable);
    end
    step();
    d_we = 1'b0; d_addr = 32'h4;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL misal_resp got rv %b err %b rd %h exp 1 1 cafef00d", d_rvalid, d_err, d_rdata);
    end
    step();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rdata !== 32'h12345678 || d_err !== 1'b0) begin
      errors++; $display("FAIL misal_reload got %h err %b exp 12345678 0", d_rdata, d_err);
    end
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic test_random();
    logic if_pend, d_pend, seen_if, seen_d;
    if_pend = 1'b0; d_pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic ed, ei;
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1'b1; if_addr = rand_addr();
      end
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom();
      end
      if_req = if_pend; d_req = d_pend;
      @(negedge clk);
      ed = model_d_wins();
      ei = if_req && !ed;
      checks++;
      if (if_gnt !== ei || d_gnt !== ed) begin
        errors++; $display("FAIL rand_gnt c%0d got if=%b d=%b exp if=%b d=%b", c, if_gnt, d_gnt, ei, ed);
      end
      checks++;
      if (mem_write_enable !== (ed && d_we && d_addr[1:0] == 2'b00)) begin
        errors++; $display("FAIL rand_we c%0d got %b", c, mem_write_enable);
      end
      checks++;
      if (mem_address !== (ed ? d_addr : if_addr)) begin
        errors++; $display("FAIL rand_addr c%0d got %h exp %h", c, mem_address, ed ? d_addr : if_addr);
      end
      checks++;
      if (if_rvalid !== exp_if_rvalid || if_rdata !== exp_if_rdata) begin
        errors++; $display("FAIL rand_ifresp c%0d got %b %h exp %b %h", c, if_rvalid, if_rdata, exp_if_rvalid, exp_if_rdata);
      end
      checks++;
      if (d_rvalid !== exp_d_rvalid || d_err !== exp_d_err || d_rdata !== exp_d_rdata) begin
        errors++; $display("FAIL rand_dresp c%0d got %b %b %h exp %b %b %h", c, d_rvalid, d_err, d_rdata,
                           exp_d_rvalid, exp_d_err, exp_d_rdata);
      end
      seen_if = if_gnt; seen_d = d_gnt;
      step();
      if (seen_if) if_pend = 1'b0;
      if (seen_d)  d_pend = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fetch_read();
    test_contention();
    test_starvation();
    test_store_load();
    test_misaligned();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
